// File: rtl/conv_encoder_frame_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : conv_encoder_frame_if                                 |
// | Purpose  : Control, input-stream and output-stream signals of    |
// |            the framed rate-1/2 convolutional encoder.            |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
interface conv_encoder_frame_if #(
    parameter int FRAME_W = 10
);
    logic [2:0]         choose_constraint_length;
    logic               start;
    logic [FRAME_W-1:0] frame_len;
    logic               in_bit;
    logic               in_valid;
    logic               in_ready;
    logic [1:0]         encoded_bits;
    logic               out_valid;
    logic               out_ready;
    logic               busy;
    logic               frame_done;

    // Encoder side
    modport slave (
        input  choose_constraint_length, start, frame_len,
        input  in_bit, in_valid, out_ready,
        output in_ready, encoded_bits, out_valid, busy, frame_done
    );

    // Source/sink side
    modport master (
        output choose_constraint_length, start, frame_len,
        output in_bit, in_valid, out_ready,
        input  in_ready, encoded_bits, out_valid, busy, frame_done
    );
endinterface
`default_nettype wire

// File: rtl/conv_encoder_frame.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : conv_encoder_frame                                    |
// | Purpose  : Rate-1/2 feed-forward convolutional encoder, K=3..6,  |
// |            one frame of data bits followed by K-1 zero tail bits |
// |            so the decoder trellis terminates in state 0.         |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
module conv_encoder_frame #(
    parameter int FRAME_W = 10
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    conv_encoder_frame_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_TAIL = 2'd2
    } state_t;

    localparam logic [FRAME_W-1:0] CNT_ONE = {{(FRAME_W-1){1'b0}}, 1'b1};

    state_t             state;
    logic [4:0]         sr;          // sr[0] = most recent past bit
    logic [2:0]         k_len;       // latched constraint length, 3..6
    logic [FRAME_W-1:0] len;         // latched frame length
    logic [FRAME_W-1:0] bit_cnt;     // data bits accepted so far
    logic [2:0]         tail_cnt;    // tail symbols issued so far
    logic [1:0]         enc;
    logic               ov;
    logic               done;

    logic               can_load;
    logic               accept;
    logic               tail_issue;
    logic               tail_finish;
    logic [2:0]         k_sel;
    logic [2:0]         km1;
    logic [FRAME_W-1:0] bit_cnt_nxt;

    // Parity pair for input u against the current shift register.
    // The tap vector {u, sr[0], .., sr[K-2]} is the top K bits of the
    // 6-bit vector below, so it is right-aligned by shifting 6-K.
    function automatic logic [1:0] code_sym(input logic u,
                                            input logic [4:0] s,
                                            input logic [2:0] k);
        logic [5:0] full;
        logic [5:0] taps;
        logic [5:0] g0;
        logic [5:0] g1;
        logic [2:0] sh;
        full = {u, s[0], s[1], s[2], s[3], s[4]};
        sh   = 3'd6 - k;
        taps = full >> sh;
        case (k)
            3'd4:    begin g0 = 6'o15; g1 = 6'o17; end
            3'd5:    begin g0 = 6'o23; g1 = 6'o35; end
            3'd6:    begin g0 = 6'o53; g1 = 6'o75; end
            default: begin g0 = 6'o07; g1 = 6'o05; end
        endcase
        return {^(taps & g0), ^(taps & g1)};
    endfunction

    // Handshake decode; a new symbol may load when the output slot is
    // empty or is being drained this cycle.
    always_comb begin
        k_sel       = ((bus.choose_constraint_length >= 3'd3) &&
                       (bus.choose_constraint_length <= 3'd6))
                      ? bus.choose_constraint_length : 3'd3;
        km1         = k_len - 3'd1;
        can_load    = !ov || bus.out_ready;
        accept      = (state == S_DATA) && can_load && bus.in_valid;
        tail_issue  = (state == S_TAIL) && (tail_cnt != km1) && can_load;
        tail_finish = (state == S_TAIL) && (tail_cnt == km1) && can_load;
        bit_cnt_nxt = bit_cnt + CNT_ONE;
    end

    assign bus.in_ready     = (state == S_DATA) && can_load;
    assign bus.encoded_bits = enc;
    assign bus.out_valid    = ov;
    assign bus.busy         = (state != S_IDLE);
    assign bus.frame_done   = done;

    // Frame sequencer, shift register and registered output symbol.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            sr       <= '0;
            k_len    <= 3'd3;
            len      <= '0;
            bit_cnt  <= '0;
            tail_cnt <= '0;
            enc      <= 2'b00;
            ov       <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        k_len    <= k_sel;
                        len      <= bus.frame_len;
                        sr       <= '0;
                        bit_cnt  <= '0;
                        tail_cnt <= '0;
                        state    <= (bus.frame_len == '0) ? S_TAIL : S_DATA;
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        enc     <= code_sym(bus.in_bit, sr, k_len);
                        ov      <= 1'b1;
                        sr      <= {sr[3:0], bus.in_bit};
                        bit_cnt <= bit_cnt_nxt;
                        if (bit_cnt_nxt == len) begin
                            state <= S_TAIL;
                        end
                    end else if (bus.out_ready) begin
                        ov <= 1'b0;
                    end
                end
                S_TAIL: begin
                    if (tail_issue) begin
                        enc      <= code_sym(1'b0, sr, k_len);
                        ov       <= 1'b1;
                        sr       <= {sr[3:0], 1'b0};
                        tail_cnt <= tail_cnt + 3'd1;
                    end else if (tail_finish) begin
                        // Last tail symbol drained (or slot already empty).
                        ov    <= 1'b0;
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end else if (bus.out_ready) begin
                        ov <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    ov    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv_encoder_frame.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : tb_conv_encoder_frame                                 |
// | Purpose  : Self-checking bench for conv_encoder_frame; expected  |
// |            symbols come from a polynomial-convolution model.     |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
module tb_conv_encoder_frame;

    localparam int FRAME_W = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    // Free-running clock
    always #5 clk = ~clk;

    conv_encoder_frame_if #(.FRAME_W(FRAME_W)) bus ();

    conv_encoder_frame #(.FRAME_W(FRAME_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    bit         in_q[$];
    logic [1:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Code symbols as the convolution of the zero-terminated bit stream
    // with each generator polynomial; generator MSB multiplies the newest bit.
    function automatic void build_model(input int ksel, input int len);
        int keff;
        int g0;
        int g1;
        int p0;
        int p1;
        bit x[$];
        keff = (ksel >= 3 && ksel <= 6) ? ksel : 3;
        case (keff)
            4:       begin g0 = 'o15; g1 = 'o17; end
            5:       begin g0 = 'o23; g1 = 'o35; end
            6:       begin g0 = 'o53; g1 = 'o75; end
            default: begin g0 = 'o7;  g1 = 'o5;  end
        endcase
        x.delete();
        for (int i = 0; i < len; i++) x.push_back(in_q[i]);
        for (int i = 0; i < keff - 1; i++) x.push_back(1'b0);
        exp_q.delete();
        for (int j = 0; j < x.size(); j++) begin
            p0 = 0;
            p1 = 0;
            for (int i = 0; i < keff; i++) begin
                if (j - i >= 0) begin
                    p0 ^= ((g0 >> (keff - 1 - i)) & 1) & int'(x[j - i]);
                    p1 ^= ((g1 >> (keff - 1 - i)) & 1) & int'(x[j - i]);
                end
            end
            exp_q.push_back({p0[0], p1[0]});
        end
    endfunction

    // rmode: 0 sink always ready, 1 pattern 1,0,0,1.., 2 random
    // vmode: 0 source valid while bits remain, 1 valid always high, 2 random
    task automatic run_frame(input string name, input int ksel, input int len,
                             input int rmode, input int vmode);
        int         idx = 0;
        int         sent = 0;
        int         cyc = 0;
        int         nsym;
        bit         finished = 1'b0;
        bit         prev_stall = 1'b0;
        logic [1:0] prev_enc = 2'b00;

        build_model(ksel, len);
        nsym = exp_q.size();

        @(negedge clk);
        bus.choose_constraint_length = 3'(ksel);
        bus.frame_len = FRAME_W'(len);
        bus.start     = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_bit    = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        chk({name, ":idle_in_ready"}, 32'(bus.in_ready), 0);
        chk({name, ":idle_busy"}, 32'(bus.busy), 0);
        @(negedge clk);
        bus.start = 1'b0;
        chk({name, ":busy_after_start"}, 32'(bus.busy), 1);

        while (!finished && cyc < 400) begin
            case (rmode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase
            case (vmode)
                0:       bus.in_valid = (sent < len);
                1:       bus.in_valid = 1'b1;
                default: bus.in_valid = (sent < len) && ($urandom_range(0, 3) != 0);
            endcase
            bus.in_bit = (sent < len) ? in_q[sent] : 1'($urandom_range(0, 1));
            #1;
            if (prev_stall) begin
                chk({name, ":stall_hold_valid"}, 32'(bus.out_valid), 1);
                chk({name, ":stall_hold_bits"}, 32'(bus.encoded_bits), 32'(prev_enc));
            end
            if (bus.out_valid && !bus.out_ready)
                chk({name, ":stall_in_ready"}, 32'(bus.in_ready), 0);
            if (bus.frame_done) begin
                chk({name, ":done_after_last"}, idx, nsym);
                finished = 1'b1;
            end
            if (bus.out_valid && bus.out_ready) begin
                chk({name, ":sym_in_range"}, 32'(idx < nsym), 1);
                if (idx < nsym)
                    chk($sformatf("%s:sym%0d", name, idx), 32'(bus.encoded_bits), 32'(exp_q[idx]));
                idx++;
            end
            if (bus.in_valid && bus.in_ready) sent++;
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_enc   = bus.encoded_bits;
            cyc++;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        #1;
        chk({name, ":finished_in_budget"}, 32'(finished), 1);
        chk({name, ":symbol_count"}, idx, nsym);
        chk({name, ":bits_consumed"}, sent, len);
        chk({name, ":busy_low_after"}, 32'(bus.busy), 0);
        chk({name, ":out_valid_low_after"}, 32'(bus.out_valid), 0);
        chk({name, ":done_single_cycle"}, 32'(bus.frame_done), 0);
    endtask

    initial begin
        int ksel;
        int len;
        bus.choose_constraint_length = 3'd3;
        bus.start     = 1'b0;
        bus.frame_len = '0;
        bus.in_bit    = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst:out_valid", 32'(bus.out_valid), 0);
        chk("rst:busy", 32'(bus.busy), 0);
        chk("rst:in_ready", 32'(bus.in_ready), 0);
        chk("rst:encoded_bits", 32'(bus.encoded_bits), 0);
        chk("rst:frame_done", 32'(bus.frame_done), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // K=3 reference frame 1,0,1,1 -> 11,10,00,01,01,11
        in_q = {1'b1, 1'b0, 1'b1, 1'b1};
        run_frame("k3_basic", 3, 4, 0, 0);
        build_model(3, 4);
        chk("k3_model_sym0", 32'(exp_q[0]), 32'h3);
        chk("k3_model_sym5", 32'(exp_q[5]), 32'h3);

        // K=4 impulse -> 11,11,01,11
        in_q = {1'b1};
        run_frame("k4_impulse", 4, 1, 0, 0);

        // Backpressure 1,0,0,1,...
        in_q = {1'b1, 1'b0, 1'b1, 1'b1};
        run_frame("k3_backpressure", 3, 4, 1, 0);

        // Empty frame, valid held high: only tail symbols, nothing consumed
        in_q.delete();
        run_frame("k5_empty", 5, 0, 0, 1);

        // Reset mid-frame after two accepted bits
        @(negedge clk);
        bus.choose_constraint_length = 3'd3;
        bus.frame_len = FRAME_W'(5);
        bus.start     = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_bit   = 1'b1;
        @(negedge clk);
        bus.in_bit   = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        chk("midrst:busy_before", 32'(bus.busy), 1);
        chk("midrst:valid_before", 32'(bus.out_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("midrst:out_valid", 32'(bus.out_valid), 0);
        chk("midrst:busy", 32'(bus.busy), 0);
        chk("midrst:in_ready", 32'(bus.in_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;
        in_q = {1'b1};
        run_frame("after_reset_k3", 3, 1, 0, 0);

        // Out-of-range K falls back to K=3
        in_q = {1'b1};
        run_frame("k7_as_k3", 7, 1, 0, 0);

        // Randomized frames, random K select, lengths, valid and ready
        for (int f = 0; f < 10; f++) begin
            ksel = int'($urandom_range(0, 7));
            len  = int'($urandom_range(0, 14));
            in_q.delete();
            for (int i = 0; i < len; i++) in_q.push_back(1'($urandom_range(0, 1)));
            run_frame($sformatf("rand%0d_k%0d_n%0d", f, ksel, len), ksel, len, 2,
                      (f % 3 == 0) ? 1 : 2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
